// File: rtl/iq_pattern_gen.sv
// IQ test-pattern generator (ramp / constant / PRBS / square) on an AXI-Stream source,
// with a loopback sink. Define IQ_PATTERN_GEN_CHECKER_EN to build the ramp checker.
module iq_pattern_gen #(
    parameter int DATA_W = 12,
    parameter int CNT_W  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic [1:0]            mode,
    input  logic [DATA_W-1:0]     step,
    input  logic [CNT_W-1:0]      burst_len,
    output logic                  out_valid,
    output logic [2*DATA_W-1:0]   out_data,
    output logic                  out_last,
    input  logic                  out_ready,
    input  logic                  in_valid,
    input  logic [2*DATA_W-1:0]   in_data,
    output logic                  in_ready,
    output logic [31:0]           rx_count,
    output logic [CNT_W-1:0]      err_count
);

    localparam logic [1:0]  MODE_RAMP   = 2'd0;
    localparam logic [1:0]  MODE_CONST  = 2'd1;
    localparam logic [1:0]  MODE_PRBS   = 2'd2;
    localparam logic [1:0]  MODE_SQUARE = 2'd3;
    localparam logic [31:0] LFSR_SEED   = 32'h0000_0001;
    localparam logic [31:0] LFSR_TAPS   = 32'h0040_0007;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic signed [DATA_W-1:0] SQ_POS = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic signed [DATA_W-1:0] SQ_NEG = {1'b1, {(DATA_W-1){1'b0}}};

    typedef enum logic {IDLE, RUN} state_t;

    state_t                    state, state_nxt;
    logic                      load, advance, hs;
    logic [1:0]                mode_r;
    logic [DATA_W-1:0]         step_r;
    logic [CNT_W-1:0]          burst_r;
    logic [CNT_W-1:0]          beat_cnt;
    logic [DATA_W-1:0]         sq_cnt;
    logic                      sq_neg;
    logic signed [DATA_W-1:0]  i_r, q_r;
    logic [31:0]               lfsr, lfsr_nxt;

    // Left-shifting Galois form of x^32+x^22+x^2+x+1.
    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        lfsr_step = s[31] ? ({s[30:0], 1'b0} ^ LFSR_TAPS) : {s[30:0], 1'b0};
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        sat_inc = (v == {CNT_W{1'b1}}) ? v : v + CNT_ONE;
    endfunction

    function automatic logic [CNT_W-1:0] beat_next(input logic [CNT_W-1:0] cnt,
                                                   input logic [CNT_W-1:0] len);
        if (len == '0)
            beat_next = sat_inc(cnt);
        else if (cnt == len - CNT_ONE)
            beat_next = '0;
        else
            beat_next = cnt + CNT_ONE;
    endfunction

    // True when the beat just sent is the last one of the current square half-period.
    function automatic logic sq_flip(input logic [DATA_W-1:0] cnt,
                                     input logic [DATA_W-1:0] half);
        logic [DATA_W:0] per;
        per = (half == '0) ? (DATA_W+1)'(1) : {1'b0, half};
        sq_flip = ({1'b0, cnt} + (DATA_W+1)'(1)) >= per;
    endfunction

    assign hs        = out_valid && out_ready;
    assign out_valid = (state == RUN);
    assign out_data  = {q_r, i_r};
    assign out_last  = (state == RUN) && (burst_r != '0) && (beat_cnt == burst_r - CNT_ONE);
    assign in_ready  = 1'b1;
    assign lfsr_nxt  = lfsr_step(lfsr);

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        advance   = 1'b0;
        case (state)
            IDLE: begin
                if (enable) begin
                    load      = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (hs) begin
                    if (enable)
                        advance = 1'b1;
                    else
                        state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Pattern state: configuration snapshot, beat counter and current output word.
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_r   <= MODE_RAMP;
            step_r   <= '0;
            burst_r  <= '0;
            beat_cnt <= '0;
            sq_cnt   <= '0;
            sq_neg   <= 1'b0;
            lfsr     <= LFSR_SEED;
            i_r      <= '0;
            q_r      <= '0;
        end else if (load) begin
            mode_r   <= mode;
            step_r   <= step;
            burst_r  <= burst_len;
            beat_cnt <= '0;
            sq_cnt   <= '0;
            sq_neg   <= 1'b0;
            lfsr     <= LFSR_SEED;
            case (mode)
                MODE_RAMP: begin
                    i_r <= '0;
                    q_r <= '0;
                end
                MODE_CONST: begin
                    i_r <= $signed(step);
                    q_r <= $signed(~step);
                end
                MODE_PRBS: begin
                    i_r <= $signed(LFSR_SEED[DATA_W-1:0]);
                    q_r <= $signed(LFSR_SEED[2*DATA_W-1:DATA_W]);
                end
                default: begin
                    i_r <= SQ_POS;
                    q_r <= '0;
                end
            endcase
        end else if (advance) begin
            beat_cnt <= beat_next(beat_cnt, burst_r);
            lfsr     <= lfsr_nxt;
            case (mode_r)
                MODE_RAMP: begin
                    i_r <= i_r + $signed(step_r);
                    q_r <= q_r - $signed(step_r);
                end
                MODE_CONST: begin
                    i_r <= i_r;
                    q_r <= q_r;
                end
                MODE_PRBS: begin
                    i_r <= $signed(lfsr_nxt[DATA_W-1:0]);
                    q_r <= $signed(lfsr_nxt[2*DATA_W-1:DATA_W]);
                end
                MODE_SQUARE: begin
                    if (sq_flip(sq_cnt, step_r)) begin
                        sq_cnt <= '0;
                        sq_neg <= ~sq_neg;
                        i_r    <= sq_neg ? SQ_POS : SQ_NEG;
                    end else begin
                        sq_cnt <= sq_cnt + DATA_W'(1);
                    end
                    q_r <= '0;
                end
                default: begin
                    i_r <= i_r;
                    q_r <= q_r;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            rx_count <= '0;
        else if (in_valid && in_ready)
            rx_count <= rx_count + 32'd1;
    end

`ifdef IQ_PATTERN_GEN_CHECKER_EN
    logic [DATA_W-1:0] exp_i;
    logic              chk_armed;
    logic [CNT_W-1:0]  err_r;
    logic [DATA_W-1:0] rx_i;
    logic              unused_rx_q;

    assign rx_i        = in_data[DATA_W-1:0];
    assign unused_rx_q = ^in_data[2*DATA_W-1:DATA_W];
    assign err_count   = err_r;

    // Every accepted beat resynchronises the expectation, so one glitch costs one error.
    always_ff @(posedge clk) begin
        if (rst) begin
            exp_i     <= '0;
            chk_armed <= 1'b0;
            err_r     <= '0;
        end else if (in_valid && in_ready) begin
            exp_i     <= rx_i + DATA_W'(1);
            chk_armed <= 1'b1;
            if (chk_armed && (rx_i != exp_i))
                err_r <= sat_inc(err_r);
        end
    end
`else
    logic unused_rx_data;

    assign unused_rx_data = ^in_data;
    assign err_count      = '0;
`endif

endmodule

// File: tb/tb_iq_pattern_gen.sv
// Scoreboard bench for iq_pattern_gen: a pattern model fills an expected-beat queue,
// a negedge monitor pops and compares on every accepted beat.
module tb_iq_pattern_gen;

    localparam int DATA_W = 12;
    localparam int CNT_W  = 16;
    localparam int OUT_W  = 2*DATA_W;
`ifdef IQ_PATTERN_GEN_CHECKER_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              enable = 1'b0;
    logic [1:0]        mode = '0;
    logic [DATA_W-1:0] step = '0;
    logic [CNT_W-1:0]  burst_len = '0;
    logic              out_valid;
    logic [OUT_W-1:0]  out_data;
    logic              out_last;
    logic              out_ready = 1'b0;
    logic              in_valid = 1'b0;
    logic [OUT_W-1:0]  in_data = '0;
    logic              in_ready;
    logic [31:0]       rx_count;
    logic [CNT_W-1:0]  err_count;

    iq_pattern_gen #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .enable(enable), .mode(mode), .step(step),
        .burst_len(burst_len), .out_valid(out_valid), .out_data(out_data),
        .out_last(out_last), .out_ready(out_ready), .in_valid(in_valid),
        .in_data(in_data), .in_ready(in_ready), .rx_count(rx_count),
        .err_count(err_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int hs_total = 0;
    logic [OUT_W:0] exp_q[$];
    bit prev_stall = 1'b0;
    logic [OUT_W:0] prev_word = '0;

    // Sink-side model state
    int          m_rx = 0;
    int          m_err = 0;
    bit          m_armed = 1'b0;
    logic [11:0] m_exp = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit rnd(input int pct);
        return $urandom_range(99, 0) < pct;
    endfunction

    // Multiply the polynomial state by x modulo x^32+x^22+x^2+x+1.
    function automatic logic [31:0] poly_mulx(input logic [31:0] s);
        logic [32:0] v;
        v = {s, 1'b0};
        if (v[32]) v = v ^ 33'h1_0040_0007;
        return v[31:0];
    endfunction

    task automatic push_expected(input int md, input int stp, input int bl, input int n);
        logic [31:0] poly;
        logic [11:0] iv, qv;
        logic        lst;
        int          per;
        poly = 32'h1;
        per  = (stp == 0) ? 1 : stp;
        for (int k = 0; k < n; k++) begin
            case (md)
                0: begin iv = 12'(k*stp); qv = 12'(-(k*stp)); end
                1: begin iv = 12'(stp); qv = ~12'(stp); end
                2: begin iv = poly[11:0]; qv = poly[23:12]; poly = poly_mulx(poly); end
                default: begin iv = (((k/per) % 2) == 1) ? 12'h800 : 12'h7FF; qv = 12'h000; end
            endcase
            lst = (bl != 0) && ((k % bl) == bl - 1);
            exp_q.push_back({lst, qv, iv});
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stall_valid", 64'(out_valid), 64'd1);
                chk("stall_hold", 64'({out_last, out_data}), 64'(prev_word));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", 64'({out_last, out_data}), 64'hDEAD_BEEF_0000_0000);
                end else begin
                    chk("beat", 64'({out_last, out_data}), 64'(exp_q.pop_front()));
                end
                hs_total++;
            end
            prev_stall = out_valid && !out_ready;
            prev_word  = {out_last, out_data};
        end
    end

    task automatic run(input int md, input int stp, input int bl, input int n,
                       input int rp, input bit stall_end, input bit scramble);
        int base, cyc;
        bit stalled;
        push_expected(md, stp, bl, n);
        @(posedge clk); #1;
        mode = 2'(md); step = 12'(stp); burst_len = 16'(bl);
        enable = 1'b1; out_ready = rnd(rp);
        base = hs_total; cyc = 0; stalled = 1'b0;
        while ((hs_total - base) < n && cyc < 2000) begin
            @(posedge clk); #1;
            cyc++;
            if ((hs_total - base) >= n) break;
            if (scramble) begin
                mode = 2'($urandom); step = 12'($urandom); burst_len = 16'($urandom);
            end
            if ((hs_total - base) == n - 1) begin
                enable = 1'b0;
                if (stall_end && !stalled) begin
                    stalled = 1'b1;
                    out_ready = 1'b0;
                    repeat (2) begin @(posedge clk); #1; end
                    out_ready = 1'b1;
                end else if (!stall_end) begin
                    out_ready = rnd(rp);
                end
            end else begin
                out_ready = rnd(rp);
            end
        end
        chk("run_beat_count", 64'(hs_total - base), 64'(n));
        enable = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        chk("run_back_to_idle", 64'(out_valid), 64'd0);
        chk("run_queue_empty", 64'(exp_q.size()), 64'd0);
        out_ready = 1'b0;
        exp_q.delete();
    endtask

    task automatic feed_sink(input logic [11:0] iv, input bit vld);
        @(posedge clk); #1;
        in_valid = vld;
        in_data  = {12'($urandom), iv};
        if (vld) begin
            m_rx++;
            if (m_armed && iv != m_exp) m_err++;
            m_exp   = iv + 12'd1;
            m_armed = 1'b1;
        end
    endtask

    task automatic sink_idle_and_check(input string tag);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk({tag, "_rx_count"}, 64'(rx_count), 64'(m_rx));
        chk({tag, "_err_count"}, 64'(err_count), CHK_EN ? 64'(m_err) : 64'd0);
    endtask

    initial begin
        logic [11:0] iv;
        logic [11:0] dir_i [5];
        dir_i[0] = 12'd5; dir_i[1] = 12'd6; dir_i[2] = 12'd7; dir_i[3] = 12'd9; dir_i[4] = 12'd10;

        repeat (3) @(posedge clk);
        #1;
        chk("reset_valid", 64'(out_valid), 64'd0);
        chk("reset_data", 64'(out_data), 64'd0);
        chk("reset_last", 64'(out_last), 64'd0);
        chk("reset_rx", 64'(rx_count), 64'd0);
        chk("reset_err", 64'(err_count), 64'd0);
        chk("in_ready", 64'(in_ready), 64'd1);
        rst = 1'b0;

        run(0, 3, 4, 10, 100, 1'b0, 1'b0);
        run(2, $urandom_range(4095, 0), $urandom_range(6, 0), 24, 50, 1'b0, 1'b0);
        run(3, 2, 0, 10, 100, 1'b0, 1'b0);
        run(3, 0, 3, 7, 60, 1'b0, 1'b0);
        run(1, $urandom_range(4095, 0), 5, 12, 40, 1'b1, 1'b0);
        run(0, 4095, 2, 9, 70, 1'b1, 1'b1);
        for (int r = 0; r < 6; r++)
            run($urandom_range(3, 0), $urandom_range(4095, 0), $urandom_range(6, 0),
                $urandom_range(20, 4), $urandom_range(90, 30), 1'($urandom), 1'($urandom));

        // Random loopback stream: mostly a ramp, with occasional jumps and idle cycles.
        iv = 12'($urandom);
        for (int k = 0; k < 60; k++) begin
            if (rnd(85)) iv = m_armed ? m_exp : iv; else iv = 12'($urandom);
            feed_sink(iv, rnd(70));
        end
        sink_idle_and_check("rand_sink");

        // Mid-burst reset.
        push_expected(0, 7, 5, 40);
        @(posedge clk); #1;
        mode = 2'd0; step = 12'd7; burst_len = 16'd5; enable = 1'b1; out_ready = 1'b1;
        repeat (6) begin @(posedge clk); #1; end
        rst = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        chk("midrst_valid", 64'(out_valid), 64'd0);
        chk("midrst_data", 64'(out_data), 64'd0);
        chk("midrst_last", 64'(out_last), 64'd0);
        chk("midrst_rx", 64'(rx_count), 64'd0);
        chk("midrst_err", 64'(err_count), 64'd0);
        @(posedge clk); #1;
        chk("midrst_hold_idle", 64'(out_valid), 64'd0);
        exp_q.delete();
        enable = 1'b0;
        rst = 1'b0;
        m_rx = 0; m_err = 0; m_armed = 1'b0; m_exp = '0;

        run(0, 1, 3, 7, 100, 1'b0, 1'b0);

        for (int k = 0; k < 5; k++) feed_sink(dir_i[k], 1'b1);
        sink_idle_and_check("dir_sink");
        chk("dir_sink_rx5", 64'(rx_count), 64'd5);
        chk("dir_sink_err", 64'(err_count), CHK_EN ? 64'd1 : 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/iq_pattern_gen.md
IQ_PATTERN_GEN -- requirements
Module: iq_pattern_gen

Interface
REQ-001 The block SHALL have parameter DATA_W, default 12, giving the width of each I and Q component in bits (legal range 4..16).
REQ-002 The block SHALL have parameter CNT_W, default 16, giving the width of the burst counter and the error counter.
REQ-003 The block SHALL have port clk, input, 1 bit, the clock; all logic is clocked on the rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit, the reset: synchronous, active-high.
REQ-005 The block SHALL have port enable, input, 1 bit, which requests generation.
REQ-006 The block SHALL have port mode, input, 2 bits, selecting the pattern: 0 ramp, 1 constant, 2 PRBS, 3 square.
REQ-007 The block SHALL have port step, input, DATA_W bits, the pattern parameter (increment, constant value or half-period).
REQ-008 The block SHALL have port burst_len, input, CNT_W bits, the beats per burst; a value of 0 means unbounded.
REQ-009 The block SHALL have port out_valid, output, 1 bit, the AXI-Stream TVALID.
REQ-010 The block SHALL have port out_data, output, 2*DATA_W bits, the AXI-Stream TDATA: I in [DATA_W-1:0] and Q in [2*DATA_W-1:DATA_W].
REQ-011 The block SHALL have port out_last, output, 1 bit, the AXI-Stream TLAST.
REQ-012 The block SHALL have port out_ready, input, 1 bit, the AXI-Stream TREADY.
REQ-013 The block SHALL have ports in_valid (input, 1 bit), in_data (input, 2*DATA_W bits) and in_ready (output, 1 bit), forming the loopback sink stream.
REQ-014 The block SHALL have port rx_count, output, 32 bits, the number of accepted input beats.
REQ-015 The block SHALL have port err_count, output, CNT_W bits, the number of checker mismatches.

Function
REQ-016 The FSM SHALL have two states, IDLE and RUN; out_valid SHALL equal 1 exactly in RUN.
REQ-017 In IDLE with enable=1, the block SHALL sample mode and step into internal registers, load the pattern seed, clear the beat counter and move to RUN on the next edge. The first beat is therefore valid one cycle after enable is seen.
REQ-018 In RUN, out_data and out_last SHALL hold stable while out_valid=1 and out_ready=0 (AXI-Stream rule).
REQ-019 On a handshake (out_valid=1 and out_ready=1), the next pattern word SHALL appear in the following cycle. If enable=0 at that handshake, the FSM SHALL return to IDLE instead. enable=0 without a handshake has no effect.
REQ-020 Changes to mode, step or burst_len while in RUN SHALL be ignored until the next IDLE->RUN transition.
REQ-021 Ramp mode: the seed is I=0, Q=0; per beat I+=step and Q-=step, modulo 2^DATA_W.
REQ-022 Constant mode: every beat is I=step and Q=~step.
REQ-023 PRBS mode: a 32-bit Galois LFSR with polynomial x^32+x^22+x^2+x+1 and seed 32'h1 SHALL advance once per beat; out_data is its low 2*DATA_W bits.
REQ-024 Square mode: I alternates between 2^(DATA_W-1)-1 and -2^(DATA_W-1), starting positive, every max(step,1) beats; Q=0.
REQ-025 out_last SHALL be 1 on the beat where the beat counter equals burst_len-1; the counter SHALL clear after that beat. When burst_len=0, out_last SHALL stay 0 and the counter SHALL saturate.
REQ-026 in_ready SHALL be constantly 1.
REQ-027 rx_count SHALL increment on every cycle with in_valid=1 and SHALL wrap at 2^32.

Reset
REQ-028 While rst=1 the block SHALL force: state IDLE, out_valid=0, out_data=0, out_last=0, LFSR=32'h1, beat counter=0, rx_count=0, err_count=0. rst SHALL take priority over every other input, including in mid-burst.

Configuration
REQ-029 Macro IQ_PATTERN_GEN_CHECKER_EN, when defined, SHALL include the ramp checker. The first accepted input beat after reset sets expected I to its I+1. Each later beat whose I differs from expected SHALL increment err_count (saturating at all-ones) and resynchronise expected to I+1; a matching beat SHALL set expected to I+1.
REQ-030 Without IQ_PATTERN_GEN_CHECKER_EN, err_count SHALL be constant 0 and no checker logic SHALL be built; rx_count is unaffected.

Verification
REQ-031 Test ramp: DATA_W=12, step=3, burst_len=4, out_ready=1. Required: I = 0,3,6,9,12 and Q = 0,0xFFD,0xFFA,…; out_last is 1 on beats 4 and 8.
REQ-032 Test backpressure: toggle out_ready randomly in PRBS mode. Required: out_data stable while stalled, and the accepted sequence starts 24'h000001, then 24'h000002 (LFSR low bits).
REQ-033 Test enable and reset: deassert enable during a stall, then raise out_ready. Required: one more beat is accepted, then IDLE. Assert rst mid-burst. Required: out_valid=0 on the next cycle and all counters 0.
REQ-034 Test square wave: step=2, DATA_W=12. Required: I = 0x7FF,0x7FF,0x800,0x800,0x7FF; with step=0, I alternates every beat.
REQ-035 Test checker (macro defined): feed in_data I = 5,6,7,9,10. Required: err_count=1 and rx_count=5. With the macro undefined: err_count=0.
